// File: rtl/cv32e40p_scnn_agu.sv
// cv32e40p_scnn_agu: SCNN address-generation unit.
// Streams one byte address per accepted LSU request for GEMM operand loads,
// tiled write-back and 2x2 max-pool window fetch.
// Optional macro SCNN_AGU_ALIGN_CHECK_EN: reject misaligned WRITEBACK jobs
// (no addresses, err_o and done_o pulse together). Without it err_o stays 0.
module cv32e40p_scnn_agu #(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 16,
    parameter int TILE_ROWS = 4,
    parameter int TILE_COLS = 4,
    parameter int BPW       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [ADDR_W-1:0] cfg_base_a_i,
    input  logic [ADDR_W-1:0] cfg_base_b_i,
    input  logic [DIM_W-1:0]  cfg_stride_a_i,
    input  logic [DIM_W-1:0]  cfg_stride_b_i,
    input  logic [DIM_W-1:0]  cfg_iters_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic              sel_b_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_GEMM = 2'd0;
    localparam logic [1:0] M_WB   = 2'd1;
    localparam logic [1:0] M_POOL = 2'd2;
    localparam bit WB_SINGLE = (TILE_ROWS == 1) && (TILE_COLS == 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_sel_b, w_sel_b_nxt;
    logic                r_last, w_last_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [ADDR_W-1:0]   r_sa, w_sa_nxt;
    logic [ADDR_W-1:0]   r_sb, w_sb_nxt;
    logic [ADDR_W-1:0]   r_a_ptr, w_a_ptr_nxt;
    logic [ADDR_W-1:0]   r_b_ptr, w_b_ptr_nxt;
    logic [ADDR_W-1:0]   r_org, w_org_nxt;      // pool window origin / write-back row base
    logic [DIM_W-1:0]    r_cnt, w_cnt_nxt;      // remaining iterations
    logic [1:0]          r_phase, w_phase_nxt;  // position inside a pool window
    logic [31:0]         r_row, w_row_nxt;
    logic [31:0]         r_col, w_col_nxt;

    logic w_accept, w_hs, w_zero, w_align_err;

    assign w_accept = (r_state == S_IDLE) && cfg_valid_i;
    assign w_hs     = r_valid && addr_ready_i;

`ifdef SCNN_AGU_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);
    assign w_align_err = (cfg_mode_i == M_WB) &&
                         (((cfg_base_a_i & ALIGN_MASK) != '0) ||
                          ((ADDR_W'(cfg_stride_a_i) & ALIGN_MASK) != '0));
`else
    assign w_align_err = 1'b0;
`endif

    // Jobs that finish without emitting a single address
    assign w_zero = (cfg_mode_i == 2'd3) ||
                    ((cfg_mode_i != M_WB) && (cfg_iters_i == '0)) ||
                    w_align_err;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_hs && r_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address sequencing: job setup on accept, step on each handshake
    always_comb begin
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_sel_b_nxt = r_sel_b;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_mode_nxt  = r_mode;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_a_ptr_nxt = r_a_ptr;
        w_b_ptr_nxt = r_b_ptr;
        w_org_nxt   = r_org;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_accept) begin
            w_mode_nxt  = cfg_mode_i;
            w_sa_nxt    = ADDR_W'(cfg_stride_a_i);
            w_sb_nxt    = ADDR_W'(cfg_stride_b_i);
            w_cnt_nxt   = cfg_iters_i;
            w_phase_nxt = 2'd0;
            w_row_nxt   = 32'd0;
            w_col_nxt   = 32'd0;
            w_a_ptr_nxt = cfg_base_a_i;
            w_b_ptr_nxt = cfg_base_b_i;
            w_org_nxt   = cfg_base_a_i;
            if (w_zero) begin
                w_done_nxt = 1'b1;
                w_err_nxt  = w_align_err;
            end else begin
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                if (cfg_mode_i == M_GEMM) begin
                    w_addr_nxt  = cfg_base_b_i;
                    w_sel_b_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_addr_nxt  = cfg_base_a_i;
                    w_sel_b_nxt = 1'b0;
                    w_last_nxt  = (cfg_mode_i == M_WB) ? WB_SINGLE : 1'b0;
                end
            end
        end else if (w_hs) begin
            if (r_last) begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_last_nxt  = 1'b0;
                w_sel_b_nxt = 1'b0;
                w_done_nxt  = 1'b1;
            end else begin
                case (r_mode)
                    M_GEMM: begin
                        if (r_sel_b) begin
                            // B accepted: present A of the same step
                            w_addr_nxt  = r_a_ptr;
                            w_sel_b_nxt = 1'b0;
                            w_last_nxt  = (r_cnt == DIM_W'(1));
                        end else begin
                            // A accepted: advance both streams
                            w_a_ptr_nxt = r_a_ptr + r_sa;
                            w_b_ptr_nxt = r_b_ptr + r_sb;
                            w_cnt_nxt   = r_cnt - DIM_W'(1);
                            w_addr_nxt  = r_b_ptr + r_sb;
                            w_sel_b_nxt = 1'b1;
                        end
                    end
                    M_WB: begin
                        if (r_col == 32'(TILE_COLS - 1)) begin
                            w_col_nxt  = 32'd0;
                            w_row_nxt  = r_row + 32'd1;
                            w_org_nxt  = r_org + r_sa;
                            w_addr_nxt = r_org + r_sa;
                            w_last_nxt = (r_row + 32'd1 == 32'(TILE_ROWS - 1)) && (TILE_COLS == 1);
                        end else begin
                            w_col_nxt  = r_col + 32'd1;
                            w_addr_nxt = r_addr + ADDR_W'(BPW);
                            w_last_nxt = (r_row == 32'(TILE_ROWS - 1)) &&
                                         (r_col + 32'd1 == 32'(TILE_COLS - 1));
                        end
                    end
                    default: begin
                        // 2x2 window: o, o+sb, o+sa, o+sa+sb, then next origin
                        w_phase_nxt = r_phase + 2'd1;
                        case (r_phase)
                            2'd0: w_addr_nxt = r_org + r_sb;
                            2'd1: w_addr_nxt = r_org + r_sa;
                            2'd2: begin
                                w_addr_nxt = r_org + r_sa + r_sb;
                                w_last_nxt = (r_cnt == DIM_W'(1));
                            end
                            default: begin
                                w_org_nxt  = r_org + (r_sb << 1);
                                w_addr_nxt = r_org + (r_sb << 1);
                                w_cnt_nxt  = r_cnt - DIM_W'(1);
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    // Registered outputs and handshake control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_sel_b <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_sel_b <= w_sel_b_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Latched job configuration and walking pointers
    always_ff @(posedge clk) begin
        r_mode  <= w_mode_nxt;
        r_sa    <= w_sa_nxt;
        r_sb    <= w_sb_nxt;
        r_a_ptr <= w_a_ptr_nxt;
        r_b_ptr <= w_b_ptr_nxt;
        r_org   <= w_org_nxt;
        r_cnt   <= w_cnt_nxt;
        r_phase <= w_phase_nxt;
        r_row   <= w_row_nxt;
        r_col   <= w_col_nxt;
    end

    assign addr_o       = r_addr;
    assign addr_valid_o = r_valid;
    assign sel_b_o      = r_sel_b;
    assign last_o       = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_cv32e40p_scnn_agu.sv
// Directed bench for cv32e40p_scnn_agu with immediate-assertion checks.
module tb_cv32e40p_scnn_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid_i;
    logic [1:0]  cfg_mode_i;
    logic [31:0] cfg_base_a_i, cfg_base_b_i;
    logic [15:0] cfg_stride_a_i, cfg_stride_b_i, cfg_iters_i;
    logic [31:0] addr_o;
    logic        addr_valid_o, addr_ready_i, sel_b_o, last_o, busy_o, done_o, err_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] got_addr[$];
    logic        got_sel[$];
    logic        got_last[$];
    logic [31:0] exp_a[$];
    logic        exp_s[$];

    cv32e40p_scnn_agu dut (
        .clk(clk), .rst(rst),
        .cfg_valid_i(cfg_valid_i), .cfg_mode_i(cfg_mode_i),
        .cfg_base_a_i(cfg_base_a_i), .cfg_base_b_i(cfg_base_b_i),
        .cfg_stride_a_i(cfg_stride_a_i), .cfg_stride_b_i(cfg_stride_b_i),
        .cfg_iters_i(cfg_iters_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .sel_b_o(sel_b_o), .last_o(last_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a config for one accepting edge, then scramble the cfg bus
    task automatic start(input logic [1:0] m, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] it);
        tick();
        cfg_mode_i = m; cfg_base_a_i = ba; cfg_base_b_i = bb;
        cfg_stride_a_i = sa; cfg_stride_b_i = sb; cfg_iters_i = it;
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i    = 1'b0;
        cfg_mode_i     = 2'($urandom);
        cfg_base_a_i   = $urandom;
        cfg_base_b_i   = $urandom;
        cfg_stride_a_i = 16'($urandom);
        cfg_stride_b_i = 16'($urandom);
        cfg_iters_i    = 16'($urandom);
    endtask

    // Drain a running job, recording accepted addresses until done_o
    task automatic collect(input bit bp);
        int          cyc = 0;
        int          last_hs = -100;
        bit          seen_done = 1'b0;
        bit          hold = 1'b0;
        logic [31:0] h_addr = '0;
        logic        h_sel = 1'b0;
        got_addr.delete(); got_sel.delete(); got_last.delete();
        check("first_valid", 32'(addr_valid_o), 32'd1);
        check("first_busy", 32'(busy_o), 32'd1);
        while (!seen_done && cyc < 400) begin
            addr_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                check("stall_addr", addr_o, h_addr);
                check("stall_sel", 32'(sel_b_o), 32'(h_sel));
                check("stall_valid", 32'(addr_valid_o), 32'd1);
                hold = 1'b0;
            end
            if (done_o) begin
                seen_done = 1'b1;
                check("done_gap", 32'(cyc - last_hs), 32'd1);
                check("done_valid", 32'(addr_valid_o), 32'd0);
                check("done_busy", 32'(busy_o), 32'd0);
            end else if (addr_valid_o) begin
                if (addr_ready_i) begin
                    got_addr.push_back(addr_o);
                    got_sel.push_back(sel_b_o);
                    got_last.push_back(last_o);
                    if (last_o) last_hs = cyc;
                end else begin
                    hold = 1'b1; h_addr = addr_o; h_sel = sel_b_o;
                end
            end
            if (!seen_done) begin
                tick();
                cyc++;
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        addr_ready_i = 1'b1;
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_count"}, 32'(got_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < got_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_a[i]);
                check($sformatf("%s_sel%0d", tag, i), 32'(got_sel[i]), 32'(exp_s[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]),
                      32'(i == exp_a.size() - 1));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, addr_o, 32'h0);
        check({tag, "_valid"}, 32'(addr_valid_o), 32'd0);
        check({tag, "_sel"}, 32'(sel_b_o), 32'd0);
        check({tag, "_last"}, 32'(last_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    task automatic set_wb_expect();
        exp_a.delete(); exp_s.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp_a.push_back(32'h100 + 32'(r) * 32'h40 + 32'(c) * 32'd4);
                exp_s.push_back(1'b0);
            end
    endtask

    initial begin
        rst = 1'b1; cfg_valid_i = 1'b0; cfg_mode_i = '0;
        cfg_base_a_i = '0; cfg_base_b_i = '0;
        cfg_stride_a_i = '0; cfg_stride_b_i = '0; cfg_iters_i = '0;
        addr_ready_i = 1'b1;
        tick(); tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // GEMM_LOAD, full throughput
        start(2'd0, 32'h1000, 32'h2000, 16'd4, 16'd8, 16'd3);
        collect(1'b0);
        exp_a = '{32'h2000, 32'h1000, 32'h2008, 32'h1004, 32'h2010, 32'h1008};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        compare_seq("gemm");

        // GEMM_LOAD with random backpressure, same expected sequence
        start(2'd0, 32'h1000, 32'h2000, 16'd4, 16'd8, 16'd3);
        collect(1'b1);
        compare_seq("gemm_bp");

        // WRITEBACK 4x4 tile
        start(2'd1, 32'h100, 32'h0, 16'h40, 16'h0, 16'd0);
        collect(1'b0);
        set_wb_expect();
        compare_seq("wb");

        // POOL, two windows
        start(2'd2, 32'h0, 32'h0, 16'h20, 16'd2, 16'd2);
        collect(1'b1);
        exp_a = '{32'h0, 32'h2, 32'h20, 32'h22, 32'h4, 32'h6, 32'h24, 32'h26};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        compare_seq("pool");

        // Zero-iteration GEMM: immediate done, no address
        start(2'd0, 32'h1000, 32'h2000, 16'd4, 16'd8, 16'd0);
        check("z_iter_done", 32'(done_o), 32'd1);
        check("z_iter_valid", 32'(addr_valid_o), 32'd0);
        check("z_iter_busy", 32'(busy_o), 32'd0);
        tick();
        check("z_iter_done_pulse", 32'(done_o), 32'd0);
        check("z_iter_valid2", 32'(addr_valid_o), 32'd0);

        // Reserved mode: immediate done, no address
        start(2'd3, 32'h1000, 32'h2000, 16'd4, 16'd8, 16'd5);
        check("mode3_done", 32'(done_o), 32'd1);
        check("mode3_valid", 32'(addr_valid_o), 32'd0);
        tick();
        check("mode3_done_pulse", 32'(done_o), 32'd0);

        // Address wrap on stream B
        start(2'd0, 32'h10, 32'hFFFF_FFF8, 16'd4, 16'd8, 16'd2);
        collect(1'b0);
        exp_a = '{32'hFFFF_FFF8, 32'h10, 32'h0, 32'h14};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        compare_seq("wrap");

        // Reset in the middle of a job: no done_o afterwards
        start(2'd0, 32'h1000, 32'h2000, 16'd4, 16'd8, 16'd3);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", 32'(done_o), 32'd0);
            check("midrst_no_valid", 32'(addr_valid_o), 32'd0);
        end

        // cfg_valid_i while busy is ignored and not queued
        start(2'd1, 32'h100, 32'h0, 16'h40, 16'h0, 16'd0);
        addr_ready_i = 1'b0;
        cfg_mode_i = 2'd0; cfg_base_a_i = 32'h5000; cfg_base_b_i = 32'h6000;
        cfg_stride_a_i = 16'd4; cfg_stride_b_i = 16'd4; cfg_iters_i = 16'd2;
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        check("busycfg_hold_addr", addr_o, 32'h100);
        check("busycfg_hold_sel", 32'(sel_b_o), 32'd0);
        collect(1'b0);
        set_wb_expect();
        compare_seq("busycfg");
        tick(); tick(); tick();
        check("busycfg_not_queued", 32'(addr_valid_o), 32'd0);
        check("busycfg_idle", 32'(busy_o), 32'd0);

        // Misaligned WRITEBACK base
        start(2'd1, 32'h102, 32'h0, 16'h40, 16'h0, 16'd0);
`ifdef SCNN_AGU_ALIGN_CHECK_EN
        check("align_err", 32'(err_o), 32'd1);
        check("align_done", 32'(done_o), 32'd1);
        check("align_valid", 32'(addr_valid_o), 32'd0);
        tick();
        check("align_err_pulse", 32'(err_o), 32'd0);
        check("align_done_pulse", 32'(done_o), 32'd0);
`else
        check("noalign_err", 32'(err_o), 32'd0);
        check("noalign_valid", 32'(addr_valid_o), 32'd1);
        check("noalign_addr", addr_o, 32'h102);
        collect(1'b0);
        check("noalign_count", 32'(got_addr.size()), 32'd16);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
